// File: rtl/md_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding,
// default operand width, fixed latency and counter width.
package md_pkg;

  localparam int unsigned MULT_N       = 32;
  // Cycles from the start-sampling edge to the done cycle, inclusive.
  localparam int unsigned MULT_LATENCY = MULT_N + 5;
  localparam int unsigned CNT_W        = $clog2(MULT_N);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPrepA = 3'd1,
    StPrepB = 3'd2,
    StCalc  = 3'd3,
    StNegLo = 3'd4,
    StNegHi = 3'd5,
    StDone  = 3'd6
  } state_e;

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle of the sequential multiplier.
//   master: drives start, is_signed, a, b, cancel; observes ready, busy, done, hi, lo
//   slave : the multiplier side (mult_seq)
interface mult_seq_if
  import md_pkg::*;
#(
  parameter int unsigned N = MULT_N
) ();

  logic         start;
  logic         is_signed;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cancel;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, is_signed, a, b, cancel,
    input  ready, busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, cancel,
    output ready, busy, done, hi, lo
  );

endinterface

// File: rtl/adder.sv
// Parameterised n-bit ripple-carry adder.
//   x, y : addends
//   ci   : carry in
//   sum  : x + y + ci (low n bits)
//   co   : carry out
module adder #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         ci,
  output logic [n-1:0] sum,
  output logic         co
);

  logic [n:0] carry;

  always_comb begin
    carry[0] = ci;
    sum      = '0;
    for (int i = 0; i < n; i++) begin
      sum[i]       = x[i] ^ y[i] ^ carry[i];
      carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
  end

  assign co = carry[n];

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle NxN -> 2N multiplier (MULT/MULTU into HI/LO).
// Radix-2 shift-add on operand magnitudes; one shared ripple adder handles
// operand negation, partial-product accumulation and result negation.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mult_seq_if (start/is_signed/a/b/cancel in,
//           ready/busy/done/hi/lo out)
module mult_seq
  import md_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_seq_if.slave   bus
);

  localparam int unsigned CntW = $clog2(N);

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            sgn_q, sgn_d;
  logic            neg_res_q, neg_res_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    acc_hi_q, acc_hi_d;
  logic [N-1:0]    acc_lo_q, acc_lo_d;
  logic            c_lo_q, c_lo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;

  logic [N-1:0]    add_x, add_y, add_sum;
  logic            add_ci, add_co;

  logic            neg_a, neg_b, is_ready, accept;

  assign neg_a    = sgn_q & a_q[N-1];
  assign neg_b    = sgn_q & b_q[N-1];
  assign is_ready = (state_q == StIdle) || (state_q == StDone);
  assign accept   = is_ready & bus.start & ~bus.cancel;

  adder #(.n(N)) u_adder (
    .x   (add_x),
    .y   (add_y),
    .ci  (add_ci),
    .sum (add_sum),
    .co  (add_co)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    neg_res_d = neg_res_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    c_lo_d    = c_lo_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    add_x     = '0;
    add_y     = '0;
    add_ci    = 1'b0;

    if (accept) begin
      a_d       = bus.a;
      b_d       = bus.b;
      sgn_d     = bus.is_signed;
      neg_res_d = bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StPrepA;
      end
      StPrepA: begin
        // |a| via ~a + 1 when negative; -2^(N-1) maps to 2^(N-1) unsigned.
        add_x   = neg_a ? ~a_q : a_q;
        add_ci  = neg_a;
        mcand_d = add_sum;
        state_d = StPrepB;
      end
      StPrepB: begin
        add_x    = neg_b ? ~b_q : b_q;
        add_ci   = neg_b;
        acc_lo_d = add_sum;
        acc_hi_d = '0;
        cnt_d    = '0;
        state_d  = StCalc;
      end
      StCalc: begin
        // Add mcand into the upper half if the multiplier LSB is set,
        // then shift {carry, acc_hi, acc_lo} right by one.
        add_x    = acc_hi_q;
        add_y    = acc_lo_q[0] ? mcand_q : '0;
        acc_hi_d = {add_co, add_sum[N-1:1]};
        acc_lo_d = {add_sum[0], acc_lo_q[N-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) state_d = StNegLo;
      end
      StNegLo: begin
        add_x    = neg_res_q ? ~acc_lo_q : acc_lo_q;
        add_ci   = neg_res_q;
        acc_lo_d = add_sum;
        c_lo_d   = add_co;
        state_d  = StNegHi;
      end
      StNegHi: begin
        // Upper half of the two's complement takes the low-half carry.
        add_x    = neg_res_q ? ~acc_hi_q : acc_hi_q;
        add_ci   = neg_res_q & c_lo_q;
        acc_hi_d = add_sum;
        hi_d     = add_sum;
        lo_d     = acc_lo_q;
        state_d  = StDone;
      end
      StDone: begin
        state_d = accept ? StPrepA : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush: abort any non-idle state; results are only committed by a
    // completed NEG_HI, so a cancel there must not touch hi/lo.
    if (bus.cancel && (state_q != StIdle)) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      c_lo_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      neg_res_q <= neg_res_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      c_lo_q    <= c_lo_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.ready = is_ready;
  assign bus.busy  = (state_q == StPrepA) || (state_q == StPrepB) || (state_q == StCalc) ||
                     (state_q == StNegLo) || (state_q == StNegHi);
  assign bus.done  = (state_q == StDone);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;
  import md_pkg::*;

  localparam int unsigned N = MULT_N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_seq_if #(.N(N)) bus ();

  mult_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-width product by plain arithmetic.
  function automatic logic [2*N-1:0] model(input bit s, input logic [N-1:0] x,
                                           input logic [N-1:0] y);
    logic signed [2*N-1:0] sx, sy;
    if (s) begin
      sx = $signed({{N{x[N-1]}}, x});
      sy = $signed({{N{y[N-1]}}, y});
      return sx * sy;
    end
    return {{N{1'b0}}, x} * {{N{1'b0}}, y};
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no pending result", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("hi", 64'(bus.hi), 64'(mon_e.hi));
        chk("lo", 64'(bus.lo), 64'(mon_e.lo));
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic push_exp(input bit s, input logic [N-1:0] x, input logic [N-1:0] y,
                          input int done_cyc);
    logic [2*N-1:0] r;
    r = model(s, x, y);
    sb.push_back('{hi: r[2*N-1:N], lo: r[N-1:0], cyc: done_cyc});
  endtask

  // Launch when ready; returns at the negedge of cycle +1.
  task automatic issue(input bit s, input logic [N-1:0] x, input logic [N-1:0] y,
                       input bit push);
    int waited = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (bus.ready !== 1'b1) chk("ready_timeout", 64'(bus.ready), 64'd1);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.a         = x;
    bus.b         = y;
    if (push) push_exp(s, x, y, cyc + int'(MULT_LATENCY));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(N - 1){1'b0}}};
      3:       v = N'(1);
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cancel    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);

    // MULTU 7 x 6 with busy window +1..+36.
    issue(1'b0, 32'd7, 32'd6, 1'b1);
    chk("busy_ready_low", 64'(bus.ready), 64'd0);
    chk("busy_c1", 64'(bus.busy), 64'd1);
    for (int k = 2; k <= 36; k++) begin
      @(negedge clk);
      chk("busy_window", 64'(bus.busy), 64'd1);
    end
    @(negedge clk);
    chk("done_busy_low", 64'(bus.busy), 64'd0);
    chk("done_ready", 64'(bus.ready), 64'd1);
    drain();

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue(1'b1, 32'hFFFF_FFFB, 32'd3, 1'b1);
    drain();
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    drain();

    // Back-to-back: start held through DONE; second operands presented while busy.
    @(negedge clk);
    t             = cyc + 1;
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.a         = 32'h1234_5678;
    bus.b         = 32'h9ABC_DEF0;
    push_exp(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, t + int'(MULT_LATENCY) - 1);
    push_exp(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, t + 2 * int'(MULT_LATENCY) - 1);
    @(negedge clk);
    bus.is_signed = 1'b1;
    bus.a         = 32'hDEAD_BEEF;
    bus.b         = 32'h0000_0123;
    while (cyc < t + int'(MULT_LATENCY)) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Start pulsed while busy is ignored.
    issue(1'b1, 32'hFFFF_FFFB, 32'd3, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd99;
    bus.b     = 32'd99;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Cancel at cycle +10 after a prior result of 42.
    issue(1'b0, 32'd7, 32'd6, 1'b1);
    drain();
    issue(1'b0, 32'd7, 32'd6, 1'b0);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_ready", 64'(bus.ready), 64'd1);
    chk("cancel_busy", 64'(bus.busy), 64'd0);
    chk("cancel_lo", 64'(bus.lo), 64'h2A);
    chk("cancel_hi", 64'(bus.hi), 64'd0);
    repeat (45) @(negedge clk);
    chk("cancel_lo_held", 64'(bus.lo), 64'h2A);

    // Cancel and start together in IDLE: no launch.
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.a      = 32'd3;
    bus.b      = 32'd3;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("cs_busy", 64'(bus.busy), 64'd0);
    chk("cs_ready", 64'(bus.ready), 64'd1);
    repeat (45) @(negedge clk);
    chk("cs_lo_held", 64'(bus.lo), 64'h2A);

    // Asynchronous reset mid-operation.
    issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 32'hFFFF_FFFB, 32'd3, 1'b1);
    drain();

    // Randomised operations, mixing idle gaps with back-to-back launches.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
      if ($urandom_range(0, 3) != 0) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
